rv32m_muldiv_unit: RTL

- Multi-cycle RV32M execute unit. It sits directly downstream of the instruction decoder.
- Consumes instructions the decoder flags with cs.m=1, using func3 plus the two operand values read from the register file.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with one shared iterative datapath.
- Stalls the pipeline through a valid/ready handshake and returns result plus destination register index to writeback.

---
 rtl/rv32m_muldiv_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32m_muldiv_unit.sv
// RV32M multiply/divide execute unit: one shared shift-add / restoring-divide
// datapath, 32 iterations per op, with a sign fix-up cycle and divide fast paths.
module rv32m_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_func3,
    input  logic [XLEN-1:0]           in_a,
    input  logic [XLEN-1:0]           in_b,
    input  logic [TAG_W-1:0]          in_rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_result,
    output logic [TAG_W-1:0]          out_rd,
    output logic [1:0]                dbg_state,
    output logic [$clog2(XLEN)-1:0]   dbg_count
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_func3;
    logic [TAG_W-1:0] r_rd;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [XLEN-1:0]  r_mag_a;
    logic [XLEN-1:0]  r_mag_b;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_result;

    logic             w_accept;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_in_sign_a;
    logic             w_in_sign_b;
    logic [XLEN-1:0]  w_in_mag_a;
    logic [XLEN-1:0]  w_in_mag_b;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_fast;
    logic [XLEN-1:0]  w_fast_result;

    logic [XLEN:0]    w_add;
    logic [XLEN:0]    w_sum;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_diff;
    logic [XLEN-1:0]  w_step_hi;
    logic [XLEN-1:0]  w_step_lo;

    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;

    // Operand decode on the incoming op; MUL is treated as unsigned since only the low word is kept.
    always_comb begin
        w_a_signed  = (in_func3 == 3'd1) || (in_func3 == 3'd2) ||
                      (in_func3 == 3'd4) || (in_func3 == 3'd6);
        w_b_signed  = (in_func3 == 3'd1) || (in_func3 == 3'd4) || (in_func3 == 3'd6);
        w_in_sign_a = w_a_signed & in_a[XLEN-1];
        w_in_sign_b = w_b_signed & in_b[XLEN-1];
        w_in_mag_a  = w_in_sign_a ? -in_a : in_a;
        w_in_mag_b  = w_in_sign_b ? -in_b : in_b;
        w_div_zero  = in_func3[2] && (in_b == '0);
        w_div_ovf   = in_func3[2] && !in_func3[0] && (in_a == MOST_NEG) && (in_b == '1);
        w_fast      = w_div_zero || w_div_ovf;
        w_fast_result = '0;
        if (w_div_zero) begin
            w_fast_result = in_func3[1] ? in_a : '1;
        end else if (w_div_ovf) begin
            w_fast_result = in_func3[1] ? '0 : MOST_NEG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        in_ready     = (r_state == S_IDLE);
        out_valid    = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    w_accept     = 1'b1;
                    w_state_next = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == LAST_STEP) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
        end
    end

    // One iteration: {hi,lo} is the product shifting right, or remainder:quotient shifting left.
    always_comb begin
        w_add   = r_lo[0] ? {1'b0, r_mag_a} : '0;
        w_sum   = {1'b0, r_hi} + w_add;
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_mag_b};
        if (r_func3[2]) begin
            w_step_hi = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            w_step_lo = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
        end else begin
            w_step_hi = w_sum[XLEN:1];
            w_step_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    always_comb begin
        w_prod     = {r_hi, r_lo};
        w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
        w_quot_fix = (r_sign_a ^ r_sign_b) ? -r_lo : r_lo;
        w_rem_fix  = r_sign_a ? -r_hi : r_hi;
        case (r_func3)
            3'd0:            w_fix_result = w_prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:      w_fix_result = w_quot_fix;
            default:         w_fix_result = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_func3  <= '0;
            r_rd     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_func3  <= in_func3;
            r_rd     <= in_rd;
            r_sign_a <= w_in_sign_a;
            r_sign_b <= w_in_sign_b;
            r_mag_a  <= w_in_mag_a;
            r_mag_b  <= w_in_mag_b;
            r_hi     <= '0;
            r_lo     <= in_func3[2] ? w_in_mag_a : w_in_mag_b;
            if (w_fast) begin
                r_result <= w_fast_result;
            end
        end else if (r_state == S_CALC) begin
            r_hi    <= w_step_hi;
            r_lo    <= w_step_lo;
            r_count <= r_count + CNT_W'(1);
        end else if (r_state == S_FIX) begin
            r_result <= w_fix_result;
        end
    end

    assign out_result = r_result;
    assign out_rd     = r_rd;
    assign dbg_state  = r_state;
    assign dbg_count  = r_count;

endmodule
